// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RV32M/RV64M unit that sits beside the execute ALU.
// It takes one MUL/DIV/REM op at a time over a valid/ready handshake. Multiplies
// go through a MUL_STAGES-deep product pipeline. Divides use an iterative
// restoring radix-2 loop followed by a sign fix-up cycle.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   op_valid_i/op_ready_o   request handshake
//   op_f3_i           funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   rs1_i, rs2_i      operands, captured when the op is accepted
//   rd_addr_i         destination register, echoed on rd_addr_o
//   flush_i           aborts whatever is in flight
//   res_valid_o/res_ready_i result handshake; res_o and rd_addr_o are held until it completes
//   busy_o            unit not idle
module execute_muldiv #(
  parameter int XLEN          = 32,
  parameter int MUL_STAGES    = 2,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [2:0]      op_f3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o
);

  localparam int CW = (XLEN == 64) ? 7 : 6;
  localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [2:0]        f3;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mul_a, mul_b;
  logic [XLEN-1:0]   quo, rem, divisor, spec_res;
  logic              q_neg, r_neg, special, fixup;

  // ---------------- operand preparation (at accept) ----------------
  logic            accept;
  logic            a_sext, b_sext, div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_next;

  assign op_ready_o  = (state == S_IDLE) && !flush_i;
  assign accept      = op_valid_i && op_ready_o;
  assign res_valid_o = (state == S_DONE);
  assign busy_o      = (state != S_IDLE);

  always_comb begin
    a_sext     = (op_f3_i == 3'd1) || (op_f3_i == 3'd2);
    b_sext     = (op_f3_i == 3'd1);
    div_signed = !op_f3_i[0];
    a_neg      = div_signed && rs1_i[XLEN-1];
    b_neg      = div_signed && rs2_i[XLEN-1];
    // Negating the most-negative value yields itself, which is also its correct unsigned magnitude.
    a_mag      = a_neg ? (~rs1_i + 1'b1) : rs1_i;
    b_mag      = b_neg ? (~rs2_i + 1'b1) : rs2_i;
    div_zero   = (rs2_i == '0);
    div_ovf    = div_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    if (div_zero)
      spec_next = op_f3_i[1] ? rs1_i : '1;
    else
      spec_next = op_f3_i[1] ? '0 : rs1_i;
  end

  // ---------------- multiply pipeline ----------------
  logic [2*XLEN-1:0] prod, mul_final;
  logic [2*XLEN-1:0] pipe [PD];
  logic [XLEN-1:0]   mul_sel;

  assign prod = mul_a * mul_b;

  // The product is only sampled after the operand registers are stable, so
  // each pipe register just needs to carry the value one stage further.
  generate
    if (MUL_STAGES > 1) begin : g_pipe
      for (genvar gi = 0; gi < MUL_STAGES - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or negedge rst) begin
            if (!rst)         pipe[gi] <= '0;
            else if (flush_i) pipe[gi] <= '0;
            else              pipe[gi] <= prod;
          end
        end else begin : g_next
          always_ff @(posedge clk or negedge rst) begin
            if (!rst)         pipe[gi] <= '0;
            else if (flush_i) pipe[gi] <= '0;
            else              pipe[gi] <= pipe[gi-1];
          end
        end
      end
      assign mul_final = pipe[MUL_STAGES-2];
    end else begin : g_nopipe
      assign pipe[0]   = '0;
      assign mul_final = prod;
    end
  endgenerate

  assign mul_sel = (f3 == 3'd0) ? mul_final[XLEN-1:0] : mul_final[2*XLEN-1:XLEN];

  // ---------------- restoring divide step ----------------
  logic [XLEN:0]   trial, diff;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, div_res;

  always_comb begin
    trial    = {rem, quo[XLEN-1]};
    diff     = trial - {1'b0, divisor};
    // rem < divisor keeps a successful difference below 2^XLEN, so bit XLEN is the borrow.
    take     = !diff[XLEN];
    rem_step = take ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], take};
    q_fix    = q_neg ? (~quo + 1'b1) : quo;
    r_fix    = r_neg ? (~rem + 1'b1) : rem;
    div_res  = special ? spec_res : (f3[1] ? r_fix : q_fix);
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      f3        <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
      spec_res  <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      special   <= 1'b0;
      fixup     <= 1'b0;
      res_o     <= '0;
      rd_addr_o <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      fixup <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3        <= op_f3_i;
            rd_addr_o <= rd_addr_i;
            mul_a     <= {{XLEN{a_sext && rs1_i[XLEN-1]}}, rs1_i};
            mul_b     <= {{XLEN{b_sext && rs2_i[XLEN-1]}}, rs2_i};
            quo       <= a_mag;
            divisor   <= b_mag;
            rem       <= '0;
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            special   <= div_zero || div_ovf;
            spec_res  <= spec_next;
            fixup     <= 1'b0;
            if (op_f3_i[2]) begin
              state <= S_DIV;
              cnt   <= CW'(XLEN - 1);
            end else begin
              state <= S_MUL;
              cnt   <= CW'(MUL_STAGES - 1);
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            res_o <= mul_sel;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (fixup || (special && (DIV_EARLY_OUT != 0))) begin
            res_o <= div_res;
            fixup <= 1'b0;
            state <= S_DONE;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
            if (cnt == '0) fixup <= 1'b1;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: begin // S_DONE
          if (res_ready_i) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv (XLEN=32, MUL_STAGES=2, DIV_EARLY_OUT=1).
// A vector table covers the arithmetic and latencies. Short hand-written sequences
// cover back-pressure, flush and asynchronous reset.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid_i = 1'b0;
  logic        op_ready_o;
  logic [2:0]  op_f3_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_o;
  logic [4:0]  rd_addr_o;
  logic        busy_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .MUL_STAGES(2), .DIV_EARLY_OUT(1)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_f3_i(op_f3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .rd_addr_o(rd_addr_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op, measure the edges from accept to res_valid_o, check the result, then hand it off.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    op_valid_i = 1'b1; op_f3_i = f3; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    chk({name, " op_ready"}, 32'(op_ready_o), 32'd1);
    @(posedge clk); #1;
    op_valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_addr_i = 5'($urandom);
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " res"}, res_o, exp);
    chk({name, " rd"}, 32'(rd_addr_o), 32'(rd));
    $display("op %-10s f3=%0d a=%h b=%h -> res=%h rd=%0d lat=%0d", name, f3, a, b, res_o, rd_addr_o, n);
    @(negedge clk); res_ready_i = 1'b1;
    @(posedge clk); #1; res_ready_i = 1'b0;
    chk({name, " valid drop"}, 32'(res_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] held;

    vt[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2};
    vt[1]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h00000000, 2};
    vt[2]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 2};
    vt[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h7FFFFFFF, 2};
    vt[4]  = '{3'd0, 32'h12345678, 32'h00000010, 5'd0,  32'h23456780, 2};
    vt[5]  = '{3'd4, 32'hFFFFFFEC, 32'd6,        5'd9,  32'hFFFFFFFD, 33};
    vt[6]  = '{3'd6, 32'hFFFFFFEC, 32'd6,        5'd10, 32'hFFFFFFFE, 33};
    vt[7]  = '{3'd5, 32'd20,       32'd6,        5'd11, 32'd3,        33};
    vt[8]  = '{3'd7, 32'd20,       32'd6,        5'd12, 32'd2,        33};
    vt[9]  = '{3'd4, 32'd100,      32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vt[10] = '{3'd6, 32'd100,      32'd0,        5'd14, 32'd100,      1};
    vt[11] = '{3'd5, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1};
    vt[12] = '{3'd7, 32'h80000001, 32'd0,        5'd16, 32'h80000001, 1};
    vt[13] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1};
    vt[14] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1};
    vt[15] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 33};
    vt[16] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd20, 32'hFFFFFFFD, 33};
    vt[17] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd21, 32'h00000001, 33};

    // Reset state
    #12;
    chk("rst res_valid", 32'(res_valid_o), 32'd0);
    chk("rst res", res_o, 32'd0);
    chk("rst rd", 32'(rd_addr_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst op_ready", 32'(op_ready_o), 32'd1);

    for (int i = 0; i < NV; i++)
      do_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].lat);

    // Back-pressure in DONE, then back-to-back accept
    @(negedge clk);
    op_valid_i = 1'b1; op_f3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; rd_addr_i = 5'd22;
    @(posedge clk); #1; op_valid_i = 1'b0;
    n = 0;
    while (!res_valid_o && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp latency", 32'(n), 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk("bp valid", 32'(res_valid_o), 32'd1);
      chk("bp res", res_o, 32'd12);
      chk("bp rd", 32'(rd_addr_o), 32'd22);
      chk("bp op_ready", 32'(op_ready_o), 32'd0);
      $display("hold cycle %0d valid=%b res=%h rd=%0d", c, res_valid_o, res_o, rd_addr_o);
      @(posedge clk); #1;
    end
    @(negedge clk); res_ready_i = 1'b1;
    @(posedge clk); #1; res_ready_i = 1'b0;
    chk("bp idle busy", 32'(busy_o), 32'd0);
    chk("bp idle op_ready", 32'(op_ready_o), 32'd1);
    do_op("b2b", 3'd7, 32'd29, 32'd5, 5'd23, 32'd4, 33);

    // Flush during DIV: no result afterwards
    @(negedge clk);
    op_valid_i = 1'b1; op_f3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7; rd_addr_i = 5'd24;
    @(posedge clk); #1; op_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush valid", 32'(res_valid_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (res_valid_o) seen++;
    end
    chk("flush no result", 32'(seen), 32'd0);
    $display("flush during DIV: busy=%b res_valid pulses=%0d", busy_o, seen);

    // Flush beats a simultaneous request in IDLE
    @(negedge clk);
    op_valid_i = 1'b1; op_f3_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2; flush_i = 1'b1;
    #1 chk("flush op_ready", 32'(op_ready_o), 32'd0);
    @(posedge clk); #1; op_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush not accepted", 32'(busy_o), 32'd0);
    $display("flush+op_valid in IDLE: busy=%b", busy_o);

    // Async reset mid-MUL; res_o holds a nonzero earlier result beforehand
    held = res_o;
    chk("pre-reset res held", held, 32'd4);
    @(negedge clk);
    op_valid_i = 1'b1; op_f3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; rd_addr_i = 5'd25;
    @(posedge clk); #1; op_valid_i = 1'b0;
    chk("mul busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("areset busy", 32'(busy_o), 32'd0);
    chk("areset valid", 32'(res_valid_o), 32'd0);
    chk("areset res", res_o, 32'd0);
    chk("areset rd", 32'(rd_addr_o), 32'd0);
    $display("async reset during MUL: busy=%b valid=%b res=%h rd=%0d", busy_o, res_valid_o, res_o, rd_addr_o);
    @(negedge clk); rst = 1'b1;
    do_op("post-rst", 3'd0, 32'd9, 32'd9, 5'd26, 32'd81, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
